// File: rtl/pwm_servo_driver.sv
// Servo/valve PWM driver: clamps handshaked width setpoints and slews the active
// width toward them, one bounded step per PWM period, updating only at period boundaries.
module pwm_servo_driver #(
  parameter int DATA_W     = 20,
  parameter int PERIOD_MAX = 1000000,
  parameter int MIN_PULSE  = 50000,
  parameter int MAX_PULSE  = 250000,
  parameter int PARK_PULSE = 150000,
  parameter int STEP       = 1000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] count,
  input  logic [DATA_W-1:0] sp_width,
  input  logic              sp_valid,
  output logic              sp_ready,
  output logic              pwm_out,
  output logic              busy,
  output logic              period_start
);

  localparam logic [DATA_W-1:0] PERIOD_MAX_W = DATA_W'(PERIOD_MAX);
  localparam logic [DATA_W-1:0] MIN_W        = DATA_W'(MIN_PULSE);
  localparam logic [DATA_W-1:0] MAX_W        = DATA_W'(MAX_PULSE);
  localparam logic [DATA_W-1:0] PARK_W       = DATA_W'(PARK_PULSE);
  localparam logic [DATA_W:0]   STEP_W       = (DATA_W+1)'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] target, target_nxt;
  logic [DATA_W-1:0] active, active_nxt;
  logic              armed;
  logic              busy_nxt;
  logic              boundary;
  logic              fault;
  logic              accept;

  function automatic logic [DATA_W-1:0] clamp_width(input logic [DATA_W-1:0] w);
    if (w < MIN_W)      clamp_width = MIN_W;
    else if (w > MAX_W) clamp_width = MAX_W;
    else                clamp_width = w;
  endfunction

  // One extra bit on the sum so active+STEP can never wrap before the compare.
  function automatic logic [DATA_W-1:0] step_up(input logic [DATA_W-1:0] cur,
                                                input logic [DATA_W-1:0] tgt);
    logic [DATA_W:0] sum;
    sum = {1'b0, cur} + STEP_W;
    if (sum >= {1'b0, tgt}) step_up = tgt;
    else                    step_up = sum[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] step_down(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] tgt);
    logic [DATA_W:0] floor_v;
    floor_v = {1'b0, tgt} + STEP_W;
    if ({1'b0, cur} <= floor_v) step_down = tgt;
    else                        step_down = cur - STEP_W[DATA_W-1:0];
  endfunction

  assign boundary = (count == PERIOD_MAX_W);
  assign fault    = (count > PERIOD_MAX_W);
  assign accept   = sp_valid & sp_ready;

  // Direction is re-evaluated every boundary against the target held before the
  // edge, so a reversal mid-ramp turns around without overshoot.
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    target_nxt = target;
    busy_nxt   = 1'b0;
    if (boundary) begin
      if (target > active) begin
        active_nxt = step_up(active, target);
        state_nxt  = (active_nxt == target) ? IDLE : RAMP_UP;
      end else if (target < active) begin
        active_nxt = step_down(active, target);
        state_nxt  = (active_nxt == target) ? IDLE : RAMP_DOWN;
      end else begin
        state_nxt  = IDLE;
      end
    end
    if (accept) target_nxt = clamp_width(sp_width);
    busy_nxt = (state_nxt != IDLE) || (target_nxt != active_nxt);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= IDLE;
      target       <= PARK_W;
      active       <= PARK_W;
      armed        <= 1'b0;
      busy         <= 1'b0;
      sp_ready     <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      active       <= active_nxt;
      busy         <= busy_nxt;
      sp_ready     <= 1'b1;
      period_start <= boundary;
      if (boundary) armed <= 1'b1;
      // Width changes land on the boundary edge, so the new width first applies at count==0.
      pwm_out      <= armed && !fault && (count < active);
    end
  end

endmodule

// File: tb/tb_pwm_servo_driver.sv
// Bench for pwm_servo_driver: fixed vector table, directed corner sequences and
// randomized traffic, all checked against a period-level reference model.
module tb_pwm_servo_driver;

  localparam int PM   = 1000000;
  localparam int MINP = 50000;
  localparam int MAXP = 250000;
  localparam int PARK = 150000;
  localparam int STEP = 1000;

  logic        clk      = 1'b0;
  logic        clr_n    = 1'b1;
  logic [19:0] count    = '0;
  logic [19:0] sp_width = '0;
  logic        sp_valid = 1'b0;
  logic        sp_ready, pwm_out, busy, period_start;

  int n_cmp = 0;
  int n_err = 0;

  int m_tgt, m_act;
  bit m_armed, m_moving, m_rdy;
  bit e_pwm, e_busy, e_ps;

  typedef struct {
    int c; int w; bit v;
    bit pwm; bit busy; bit ps; bit rdy;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  pwm_servo_driver dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .count        (count),
    .sp_width     (sp_width),
    .sp_valid     (sp_valid),
    .sp_ready     (sp_ready),
    .pwm_out      (pwm_out),
    .busy         (busy),
    .period_start (period_start)
  );

  function automatic int clampw(input int w);
    if (w < MINP) return MINP;
    if (w > MAXP) return MAXP;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tgt = PARK; m_act = PARK; m_armed = 0; m_moving = 0; m_rdy = 0;
    e_pwm = 0; e_busy = 0; e_ps = 0;
  endtask

  // One clock: apply inputs, advance the model over the edge, compare outputs.
  task automatic cyc(input int c, input int w, input bit v);
    bit bnd;
    int old_t;
    count = 20'(c); sp_width = 20'(w); sp_valid = v;
    @(posedge clk);
    bnd   = (c == PM);
    old_t = m_tgt;
    e_pwm = m_armed && (c <= PM) && (c < m_act);
    e_ps  = bnd;
    if (bnd) begin
      m_armed = 1;
      if (old_t > m_act)      m_act = (m_act + STEP < old_t) ? m_act + STEP : old_t;
      else if (old_t < m_act) m_act = (m_act - STEP > old_t) ? m_act - STEP : old_t;
      m_moving = (m_act != old_t);
    end
    if (v && m_rdy) m_tgt = clampw(w);
    e_busy = m_moving || (m_tgt != m_act);
    m_rdy  = 1;
    #1;
    chk("pwm_out",      32'(pwm_out),      32'(e_pwm));
    chk("busy",         32'(busy),         32'(e_busy));
    chk("period_start", 32'(period_start), 32'(e_ps));
    chk("sp_ready",     32'(sp_ready),     32'(m_rdy));
  endtask

  task automatic do_reset();
    #2 clr_n = 1'b0;
    #1;
    chk("rst_pwm_async", 32'(pwm_out),      0);
    chk("rst_busy",      32'(busy),         0);
    chk("rst_ps",        32'(period_start), 0);
    chk("rst_ready",     32'(sp_ready),     0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Run boundaries (probing the width edge each period) until busy drops.
  task automatic ramp(input string name, input int exp_n, input int limit);
    int n;
    bit done;
    n = 0; done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      cyc(PM, 0, 0);
      n++;
      cyc(m_act - 1, 0, 0);
      cyc(m_act, 0, 0);
      if (busy === 1'b0) done = 1;
    end
    chk(name, n, exp_n);
  endtask

  initial begin
    tbl[0]  = '{0,      0,      0, 0, 0, 0, 1};
    tbl[1]  = '{149999, 0,      0, 0, 0, 0, 1};
    tbl[2]  = '{PM,     0,      0, 0, 0, 1, 1};
    tbl[3]  = '{0,      0,      0, 1, 0, 0, 1};
    tbl[4]  = '{149999, 0,      0, 1, 0, 0, 1};
    tbl[5]  = '{150000, 0,      0, 0, 0, 0, 1};
    tbl[6]  = '{500,    151500, 1, 1, 1, 0, 1};
    tbl[7]  = '{150999, 0,      0, 0, 1, 0, 1};
    tbl[8]  = '{PM,     0,      0, 0, 1, 1, 1};
    tbl[9]  = '{150999, 0,      0, 1, 1, 0, 1};
    tbl[10] = '{151000, 0,      0, 0, 1, 0, 1};
    tbl[11] = '{PM,     0,      0, 0, 0, 1, 1};
    tbl[12] = '{151499, 0,      0, 1, 0, 0, 1};
    tbl[13] = '{151500, 0,      0, 0, 0, 0, 1};
    tbl[14] = '{1048575,0,      0, 0, 0, 0, 1};
    tbl[15] = '{0,      0,      0, 1, 0, 0, 1};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].c, tbl[i].w, tbl[i].v);
      chk($sformatf("tbl%0d_pwm", i),  32'(pwm_out),      32'(tbl[i].pwm));
      chk($sformatf("tbl%0d_busy", i), 32'(busy),         32'(tbl[i].busy));
      chk($sformatf("tbl%0d_ps", i),   32'(period_start), 32'(tbl[i].ps));
      chk($sformatf("tbl%0d_rdy", i),  32'(sp_ready),     32'(tbl[i].rdy));
    end

    // Clamp high: overwrite before the boundary, full ramp from park to max.
    do_reset();
    cyc(PM, 0, 0);
    cyc(500, 10, 1);
    chk("clamp_lo_busy", 32'(busy), 1);
    cyc(0, 400000, 1);
    ramp("ramp_up_periods", 100, 150);
    cyc(249999, 0, 0);
    chk("at_max_pwm_hi", 32'(pwm_out), 1);
    cyc(250000, 0, 0);
    chk("at_max_pwm_lo", 32'(pwm_out), 0);

    // Clamp low: full ramp down to the minimum.
    cyc(500, 10, 1);
    ramp("ramp_down_periods", 200, 250);
    cyc(49999, 0, 0);
    chk("at_min_pwm_hi", 32'(pwm_out), 1);

    // Accept coincident with the boundary uses the old target.
    cyc(PM, 100000, 1);
    cyc(49999, 0, 0);
    chk("coinc_old_hi", 32'(pwm_out), 1);
    cyc(50000, 0, 0);
    chk("coinc_old_lo", 32'(pwm_out), 0);
    cyc(PM, 0, 0);
    cyc(50999, 0, 0);
    chk("coinc_new_hi", 32'(pwm_out), 1);
    cyc(51000, 0, 0);
    chk("coinc_new_lo", 32'(pwm_out), 0);

    // Reversal while ramping up at 160000.
    do_reset();
    cyc(PM, 0, 0);
    cyc(100, 170000, 1);
    for (int i = 0; i < 10; i++) cyc(PM, 0, 0);
    cyc(159999, 0, 0);
    chk("rev_start_hi", 32'(pwm_out), 1);
    cyc(160000, 0, 0);
    chk("rev_start_lo", 32'(pwm_out), 0);
    cyc(100, 155000, 1);
    cyc(PM, 0, 0);
    cyc(158999, 0, 0);
    chk("rev_first_hi", 32'(pwm_out), 1);
    cyc(159000, 0, 0);
    chk("rev_first_lo", 32'(pwm_out), 0);
    ramp("rev_periods", 4, 10);
    cyc(155000, 0, 0);
    chk("rev_final_lo", 32'(pwm_out), 0);

    // Reset in the middle of a 200000-wide pulse.
    cyc(100, 200000, 1);
    ramp("to_200k_periods", 45, 60);
    cyc(0, 0, 0);
    cyc(80000, 0, 0);
    chk("midpulse_hi", 32'(pwm_out), 1);
    do_reset();
    cyc(0, 0, 0);
    chk("post_rst_unarmed", 32'(pwm_out), 0);
    cyc(PM, 0, 0);
    cyc(0, 0, 0);
    chk("post_rst_first_hi", 32'(pwm_out), 1);
    cyc(149999, 0, 0);
    chk("post_rst_park_hi", 32'(pwm_out), 1);
    cyc(150000, 0, 0);
    chk("post_rst_park_lo", 32'(pwm_out), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int r, c, w;
      r = int'($urandom_range(0, 9));
      if (r < 2)       c = PM;
      else if (r == 2) c = PM + 1 + int'($urandom_range(0, 48574));
      else if (r < 6)  c = m_act - 1 + int'($urandom_range(0, 2));
      else             c = int'($urandom_range(0, PM));
      if ($urandom_range(0, 1) == 0) w = int'($urandom_range(0, 1048575));
      else                           w = int'($urandom_range(40000, 260000));
      cyc(c, w, $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
